// File: rtl/eth_clken_pkg.sv
// ============================================================================
// Module   : eth_clken_pkg
// Brief    : Speed codes and FSM state type shared by the Ethernet clock-enable
//            generator and its per-channel dividers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package eth_clken_pkg;

    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_100M  = 2'b01;
    localparam logic [1:0] SPD_1000M = 2'b10;
    localparam logic [1:0] SPD_OFF   = 2'b11;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/eth_clken_div.sv
// ============================================================================
// Module   : eth_clken_div
// Brief    : One channel: period counter, clock-enable pulse and the applied
//            speed register, which only changes at a period boundary.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_clken_div
    import eth_clken_pkg::*;
#(
    parameter int DIV_100M = 5,
    parameter int DIV_10M  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_run_nxt,
    input  logic [1:0] i_speed,
    output logic       o_clken,
    output logic [1:0] o_speed_act
);

    localparam int            CW          = (DIV_10M > 1) ? $clog2(DIV_10M) : 1;
    localparam logic [CW-1:0] c_LAST_10M  = CW'(DIV_10M - 1);
    localparam logic [CW-1:0] c_LAST_100M = CW'(DIV_100M - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_speed_act;
    logic [CW-1:0] w_last;
    logic          w_off;
    logic          w_term;
    logic          w_load;

    always_comb begin
        w_last = '0;
        case (r_speed_act)
            SPD_10M:  w_last = c_LAST_10M;
            SPD_100M: w_last = c_LAST_100M;
            default:  w_last = '0;
        endcase
    end

    assign w_off  = (r_speed_act == SPD_OFF);
    assign w_term = i_run && !w_off && (r_cnt == w_last);
    // Speed is taken on RUN entry so the first period already uses it.
    assign w_load = (i_run_nxt && !i_run) || (i_run && (w_term || w_off));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_speed_act <= SPD_OFF;
        end else begin
            if (!(i_run && i_run_nxt) || w_off || w_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_load) begin
                r_speed_act <= i_speed;
            end
        end
    end

    assign o_clken     = w_term;
    assign o_speed_act = r_speed_act;

endmodule

`default_nettype wire

// File: rtl/eth_clken_gen.sv
// ============================================================================
// Module   : eth_clken_gen
// Brief    : PLL lock qualification and per-channel MAC clock-enable pulses.
//            Optional lock-loss counter enabled by ETH_CLKEN_LOSS_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_clken_gen
    import eth_clken_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int LOCK_CYCLES = 1024,
    parameter int DIV_100M    = 5,
    parameter int DIV_10M     = 50
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic [2*NUM_CH-1:0] speed,
    output logic [NUM_CH-1:0]   clken,
    output logic [2*NUM_CH-1:0] speed_act,
`ifdef ETH_CLKEN_LOSS_CNT_EN
    output logic [7:0]          lock_loss_cnt,
`endif
    output logic                ready
);

    localparam int            QW     = $clog2(LOCK_CYCLES + 1);
    localparam logic [QW-1:0] c_QLAST = QW'(LOCK_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_lk;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [QW-1:0] r_qcnt;
    logic [QW-1:0] w_qcnt_nxt;
    logic          w_run;
    logic          w_run_nxt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lk = r_sync2;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        case (r_state)
            ST_UNLOCKED: begin
                w_qcnt_nxt = '0;
                if (w_lk) begin
                    w_state_nxt = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!w_lk) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_qcnt_nxt  = '0;
                end else if (r_qcnt == c_QLAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_qcnt_nxt = r_qcnt + QW'(1);
                end
            end
            ST_RUN: begin
                if (!w_lk) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    assign w_run     = (r_state == ST_RUN);
    assign w_run_nxt = (w_state_nxt == ST_RUN);
    assign ready     = w_run;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            eth_clken_div #(
                .DIV_100M (DIV_100M),
                .DIV_10M  (DIV_10M)
            ) u_div (
                .clk         (refclk),
                .rst         (rst),
                .i_run       (w_run),
                .i_run_nxt   (w_run_nxt),
                .i_speed     (speed[2*c +: 2]),
                .o_clken     (clken[c]),
                .o_speed_act (speed_act[2*c +: 2])
            );
        end
    endgenerate

`ifdef ETH_CLKEN_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (w_run && !w_run_nxt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_clken_gen.sv
// ============================================================================
// Module   : tb_eth_clken_gen
// Brief    : Self-checking bench for eth_clken_gen (3 channels, 16-cycle lock
//            qualification); honours ETH_CLKEN_LOSS_CNT_EN when defined.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_eth_clken_gen;

    localparam int NCH  = 3;
    localparam int LC   = 16;
    localparam int D100 = 5;
    localparam int D10  = 50;
`ifdef ETH_CLKEN_LOSS_CNT_EN
    localparam int REPS = 300;
`else
    localparam int REPS = 3;
`endif

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic [5:0] speed      = 6'h3F;
    logic [2:0] clken;
    logic [5:0] speed_act;
    logic       ready;
`ifdef ETH_CLKEN_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    always #4 clk = ~clk;

    eth_clken_gen #(
        .NUM_CH      (NCH),
        .LOCK_CYCLES (LC),
        .DIV_100M    (D100),
        .DIV_10M     (D10)
    ) dut (
        .refclk        (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .speed         (speed),
        .clken         (clken),
        .speed_act     (speed_act),
`ifdef ETH_CLKEN_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .ready         (ready)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: RUN holds once lk has been high for LC+1 consecutive
    // edges; each channel counts down to its next pulse.
    bit m_s1, m_s2, m_run;
    int m_ones, m_loss;
    int m_act[NCH];
    int m_left[NCH];

    typedef struct packed {
        logic [5:0]      spd;
        logic [2:0][7:0] first;
        logic [2:0][7:0] cnt;
    } vec_t;

    vec_t tbl[4];
    int   n, p_first, p_second, p_cnt;
    int   fst[NCH];
    int   cntp[NCH];

    function automatic int div_of(input int code);
        case (code)
            0:       return D10;
            1:       return D100;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_run = 0; m_ones = 0; m_loss = 0;
        for (int c = 0; c < NCH; c++) begin
            m_act[c]  = 3;
            m_left[c] = 0;
        end
    endtask

    task automatic model_step();
        bit lk, was_run;
        int s;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        was_run = m_run;
        m_ones  = lk ? m_ones + 1 : 0;
        m_run   = (m_ones > LC);
        for (int c = 0; c < NCH; c++) begin
            s = int'(speed[2*c +: 2]);
            if (was_run) begin
                if (m_act[c] == 3 || m_left[c] == 0) begin
                    m_act[c]  = s;
                    m_left[c] = div_of(s) - 1;
                end else begin
                    m_left[c]--;
                end
            end else if (m_run) begin
                m_act[c]  = s;
                m_left[c] = div_of(s) - 1;
            end
        end
        if (was_run && !m_run && m_loss < 255) m_loss++;
    endtask

    task automatic check_outputs();
        logic [2:0] ek;
        logic [5:0] ea;
        for (int c = 0; c < NCH; c++) begin
            ek[c]         = m_run && (m_act[c] != 3) && (m_left[c] == 0);
            ea[2*c +: 2]  = 2'(m_act[c]);
        end
        chk("ready", ready, m_run);
        chk("clken", clken, ek);
        chk("speed_act", speed_act, ea);
`ifdef ETH_CLKEN_LOSS_CNT_EN
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        tbl[0] = vec_t'{spd: 6'b10_01_00, first: {8'd0,   8'd4,   8'd49}, cnt: {8'd100, 8'd20, 8'd2}};
        tbl[1] = vec_t'{spd: 6'b01_00_11, first: {8'd4,   8'd49,  8'd255}, cnt: {8'd20,  8'd2,  8'd0}};
        tbl[2] = vec_t'{spd: 6'b10_10_10, first: {8'd0,   8'd0,   8'd0},  cnt: {8'd100, 8'd100, 8'd100}};
        tbl[3] = vec_t'{spd: 6'b11_11_11, first: {8'd255, 8'd255, 8'd255}, cnt: {8'd0,  8'd0,  8'd0}};
        model_reset();

        // Lock latency with pll_locked high through reset release
        pll_locked = 1'b1;
        speed      = 6'b10_01_00;
        do_reset();
        chk("reset_ready", ready, 0);
        chk("reset_speed_act", speed_act, 6'h3F);
        wait_ready(n);
        chk("lock_latency", n, 19);

        // One-cycle lock glitch at qualify count 10 restarts qualification
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            pll_locked = (k == 12) ? 1'b0 : 1'b1;
            tick();
            if (k == 30) chk("glitch_not_ready", ready, 0);
            if (k == 31) chk("glitch_ready", ready, 1);
        end

        // Table: first pulse cycle and pulse count over 100 RUN cycles
        for (int v = 0; v < 4; v++) begin
            speed = tbl[v].spd;
            do_reset();
            wait_ready(n);
            for (int c = 0; c < NCH; c++) begin
                fst[c]  = 255;
                cntp[c] = 0;
            end
            for (int r = 0; r < 100; r++) begin
                if (r > 0) tick();
                for (int c = 0; c < NCH; c++) begin
                    if (clken[c]) begin
                        if (fst[c] == 255) fst[c] = r;
                        cntp[c]++;
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("vec%0d_first_ch%0d", v, c), fst[c], tbl[v].first[c]);
                chk($sformatf("vec%0d_count_ch%0d", v, c), cntp[c], tbl[v].cnt[c]);
            end
        end

        // 10M -> 100M at count 20: period completes, then 5-cycle periods
        speed = 6'b10_11_00;
        do_reset();
        wait_ready(n);
        p_first = -1; p_second = -1; p_cnt = 0;
        for (int r = 0; r <= 66; r++) begin
            if (clken[0]) begin
                p_cnt++;
                if (p_first < 0)       p_first  = r;
                else if (p_second < 0) p_second = r;
            end
            if (r == 49) chk("chg_act_before", speed_act[1:0], 2'b00);
            if (r == 50) chk("chg_act_after", speed_act[1:0], 2'b01);
            if (r == 20) speed[1:0] = 2'b01;
            tick();
        end
        chk("chg_first_pulse", p_first, 49);
        chk("chg_second_pulse", p_second, 54);
        chk("chg_pulse_count", p_cnt, 4);

        // Lock loss in RUN, repeated for counter saturation
        speed = 6'b10_01_00;
        for (int i = 0; i < REPS; i++) begin
            pll_locked = 1'b1;
            wait_ready(n);
            if (i == 0) chk("relock_ready", ready, 1);
            pll_locked = 1'b0;
            tick();
            if (i == 0) chk("drop_t1_ready", ready, 1);
            tick();
            if (i == 0) chk("drop_t2_ready", ready, 1);
            tick();
            if (i == 0) begin
                chk("drop_t3_ready", ready, 0);
                chk("drop_t3_clken", clken, 0);
            end
        end
`ifdef ETH_CLKEN_LOSS_CNT_EN
        chk("loss_saturated", lock_loss_cnt, 255);
`endif

        // Asynchronous reset in the middle of RUN, away from any clock edge
        pll_locked = 1'b1;
        wait_ready(n);
        repeat (7) tick();
        #1 rst = 1'b1;
        #1 model_reset();
        chk("async_rst_ready", ready, 0);
        chk("async_rst_clken", clken, 0);
        chk("async_rst_speed_act", speed_act, 6'h3F);
        repeat (2) tick();
        rst = 1'b0;

        // Randomised lock drops and speed changes
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 299) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pll_locked = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) speed[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
